ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, RAM word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, RAM address width; depth = 2**ADDR_WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  2  per-requester access request (index 0, 1).
REQ-006 req_we  input  2  per-requester write enable; 0 = read.
REQ-007 req_addr  input  2 x ADDR_WIDTH  per-requester address.
REQ-008 req_wdata  input  2 x DATA_WIDTH  per-requester write data.
REQ-009 req_ready  output  2  grant; transfer occurs when req_valid[i] and req_ready[i] are both high at a clock edge.
REQ-010 rsp_valid  output  2  read data valid for requester i, one cycle.
REQ-011 rsp_rdata  output  DATA_WIDTH  read data, shared by both requesters, qualified by rsp_valid.
REQ-012 init_done  output  1  high once the post-reset memory clear has completed.
REQ-013 ram_addr  output  ADDR_WIDTH  to RAM addr.
REQ-014 ram_din  output  DATA_WIDTH  to RAM din.
REQ-015 ram_we  output  1  to RAM we.
REQ-016 ram_dout  input  DATA_WIDTH  from RAM dout; registered, valid one cycle after address is sampled.

Function
REQ-017 FSM states: INIT, ARB; rst forces INIT.
REQ-018 INIT: ram_we=1, ram_din=0, ram_addr=init counter, counting 0 to 2**ADDR_WIDTH-1, one address per cycle; req_ready=0.
REQ-019 INIT -> ARB on the edge where the init counter equals 2**ADDR_WIDTH-1; init_done goes high on that edge and stays high until rst.
REQ-020 ARB: at most one req_ready bit high per cycle; req_ready is combinational from req_valid and the priority pointer.
REQ-021 Round-robin: the priority pointer names the preferred requester; if only one requester is valid it is granted regardless of the pointer.
REQ-022 When both are valid, the pointer's requester is granted; after any grant the pointer moves to the other requester.
REQ-023 No valid request: ram_we=0, ram_addr holds last value, req_ready=0, pointer unchanged.
REQ-024 Granted cycle: ram_addr, ram_din and ram_we are driven combinationally from the granted requester.
REQ-025 Granted read at edge N: rsp_valid[owner]=1 and rsp_rdata=ram_dout during the cycle after edge N, for exactly one cycle.
REQ-026 Back-to-back reads, including reads from alternating requesters, are supported at one per cycle; the pending owner register is overwritten every edge.
REQ-027 Granted writes produce no rsp_valid.
REQ-028 Read-after-write to the same address in consecutive cycles returns the new data (the RAM write completes before the next read is sampled).
REQ-029 rsp_valid is never asserted for both requesters in the same cycle.

Reset
REQ-030 On rst: state=INIT, init counter=0, init_done=0, pointer=0, rsp_valid=0, pending-read flag=0, req_ready=0.
REQ-031 rst mid-operation discards any in-flight read (no rsp_valid in the next cycle) and restarts the memory clear from address 0.

Structure
REQ-032 Package ram_arb_pkg holds NUM_REQ=2 and the state enum (INIT, ARB).
REQ-033 The grant logic is a sub-module rr_arbiter2: inputs valid[1:0] and pointer; outputs a one-hot grant.

Verification
REQ-034 Reset, then idle with ADDR_WIDTH=4 -> ram_we=1 for exactly 16 cycles on addresses 0..15 with din=0; init_done rises after the 16th edge.
REQ-035 After init, requester 0 writes 0xA5 to addr 3, then reads addr 3 -> rsp_valid[0] one cycle after the read grant with rsp_rdata=0xA5.
REQ-036 Both requesters hold reads continuously (r0 addr 1, r1 addr 2) -> grants alternate 0,1,0,1; rsp_valid alternates, with no cycle in which both bits are high.
REQ-037 After init, read addr 7 with no prior write -> rsp_rdata=0x00.
REQ-038 Only requester 1 valid for 4 cycles with pointer=1 -> granted every cycle with no idle slots.
REQ-039 Assert rst the cycle after a read grant -> no rsp_valid, init_done=0, and the clear restarts at address 0.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants and FSM state type for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic {
        INIT,
        ARB
    } state_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM arbiter: per-requester request/grant plus shared read response.
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);

    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_we;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]                 req_ready;
    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [DATA_WIDTH-1:0]              rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the pointer.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (valid_i == 2'b11) begin
            grant_o = ptr_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Clears the RAM after reset, then shares its single port between two requesters round-robin.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_port_arbiter_if.slave     bus,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic                  init_done_q;
    logic                  ptr_q;
    logic                  pend_q;
    logic                  owner_q;

    logic [NUM_REQ-1:0]    arb_valid;
    logic [NUM_REQ-1:0]    grant;
    logic                  any_gnt;
    logic                  gnt_idx;

    // Gating with rst keeps grants and an in-flight response invisible during the reset cycle.
    assign arb_valid = (state_q == ARB && !rst) ? bus.req_valid : '0;

    rr_arbiter2 u_rr_arbiter2 (
        .valid_i (arb_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    assign any_gnt       = |grant;
    assign gnt_idx       = grant[1];
    assign bus.req_ready = grant;
    assign bus.rsp_valid = (pend_q && !rst) ? (owner_q ? 2'b10 : 2'b01) : '0;
    assign bus.rsp_rdata = ram_dout;
    assign init_done     = init_done_q;

    always_comb begin
        ram_we   = 1'b0;
        ram_din  = '0;
        ram_addr = last_addr_q;
        if (state_q == INIT) begin
            ram_we   = 1'b1;
            ram_addr = init_cnt_q;
        end else if (any_gnt) begin
            ram_we   = bus.req_we[gnt_idx];
            ram_addr = bus.req_addr[gnt_idx];
            ram_din  = bus.req_wdata[gnt_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            last_addr_q <= '0;
            init_done_q <= 1'b0;
            ptr_q       <= 1'b0;
            pend_q      <= 1'b0;
            owner_q     <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    pend_q      <= 1'b0;
                    last_addr_q <= init_cnt_q;
                    if (init_cnt_q == '1) begin
                        state_q     <= ARB;
                        init_done_q <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                ARB: begin
                    // The pending owner is rewritten every edge so reads can issue back to back.
                    pend_q  <= any_gnt && !bus.req_we[gnt_idx];
                    owner_q <= gnt_idx;
                    if (any_gnt) begin
                        ptr_q       <= ~gnt_idx;
                        last_addr_q <= ram_addr;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: stimulus pushes expected read responses, a monitor checks them.
module tb_ram_port_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    typedef struct {
        logic          owner;
        logic [DW-1:0] data;
    } rsp_t;

    logic          clk;
    logic          rst;
    logic          init_done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic          fill;
    logic [DW-1:0] mem [16];

    int   checks;
    int   errors;
    rsp_t exp_q [$];

    ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .init_done (init_done),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered read-first RAM; prefilled with 0xFF so the clear is observable.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'hFF;
            ram_dout <= 8'hFF;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, entered and left at posedge+1.
    task automatic cyc(input logic [1:0] v, input logic [1:0] we,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [1:0] exp_rdy,
                       input logic [DW-1:0] x0, input logic [DW-1:0] x1);
        rsp_t r;
        logic idx;
        bus.req_valid    = v;
        bus.req_we       = we;
        bus.req_addr[0]  = a0;
        bus.req_addr[1]  = a1;
        bus.req_wdata[0] = d0;
        bus.req_wdata[1] = d1;
        @(negedge clk);
        chk("req_ready", {30'd0, bus.req_ready}, {30'd0, exp_rdy});
        if (exp_rdy != 2'b00) begin
            idx = exp_rdy[1];
            chk("ram_we", {31'd0, ram_we}, {31'd0, we[idx]});
            chk("ram_addr", {28'd0, ram_addr}, {28'd0, idx ? a1 : a0});
            if (we[idx]) begin
                chk("ram_din", {24'd0, ram_din}, {24'd0, idx ? d1 : d0});
            end else begin
                r.owner = idx;
                r.data  = idx ? x1 : x0;
                exp_q.push_back(r);
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
    endtask

    // Response monitor.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid !== 2'b00) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid %b expected none at %0t", bus.rsp_valid, $time);
                end else begin
                    r = exp_q.pop_front();
                    chk("rsp_valid", {30'd0, bus.rsp_valid}, r.owner ? 32'd2 : 32'd1);
                    chk("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, r.data});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish by 200000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        fill   = 1'b1;
        rst    = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_we    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        @(negedge clk);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        fill = 1'b0;
        rst  = 1'b0;

        // Memory clear: 16 writes of zero, requests ignored.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("init_we", {31'd0, ram_we}, 32'd1);
            chk("init_addr", {28'd0, ram_addr}, i);
            chk("init_din", {24'd0, ram_din}, 32'd0);
            chk("init_ready", {30'd0, bus.req_ready}, 32'd0);
            chk("init_done_low", {31'd0, init_done}, 32'd0);
            @(posedge clk);
        end
        #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("init_done_high", {31'd0, init_done}, 32'd1);
        chk("idle_we", {31'd0, ram_we}, 32'd0);
        chk("idle_addr_hold", {28'd0, ram_addr}, 32'd15);
        @(posedge clk);
        #1;

        // Write then immediate read-back by requester 0; then an untouched address.
        cyc(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00, 2'b01, 8'h00, 8'h00);
        cyc(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00, 2'b01, 8'hA5, 8'h00);
        cyc(2'b01, 2'b00, 4'd7, 4'd0, 8'h00, 8'h00, 2'b01, 8'h00, 8'h00);

        // Pointer now 1: requester 1 alone is granted every cycle.
        for (int i = 0; i < 4; i++) begin
            cyc(2'b10, 2'b10, 4'd0, 4'(8 + i), 8'h00, 8'(8'h10 + i), 2'b10, 8'h00, 8'h00);
        end

        // Both hold reads: grants alternate starting with requester 0.
        for (int i = 0; i < 6; i++) begin
            cyc(2'b11, 2'b00, 4'd9, 4'd10, 8'h00, 8'h00,
                (i % 2 == 0) ? 2'b01 : 2'b10, 8'h11, 8'h12);
        end
        cyc(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00);
        chk("idle_hold_after_arb", {28'd0, ram_addr}, 32'd10);

        // Read granted, then reset in the following cycle: the response is dropped.
        bus.req_valid   = 2'b01;
        bus.req_we      = 2'b00;
        bus.req_addr[0] = 4'd9;
        @(negedge clk);
        chk("abort_ready", {30'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        chk("abort_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reinit_rsp_valid", {30'd0, bus.rsp_valid}, 32'd0);
        chk("reinit_done", {31'd0, init_done}, 32'd0);
        chk("reinit_addr", {28'd0, ram_addr}, 32'd0);
        chk("reinit_we", {31'd0, ram_we}, 32'd1);
        repeat (16) @(posedge clk);
        #1;
        chk("reinit_done_high", {31'd0, init_done}, 32'd1);

        // Data written before the reset must be cleared.
        cyc(2'b01, 2'b00, 4'd9, 4'd0, 8'h00, 8'h00, 2'b01, 8'h00, 8'h00);
        cyc(2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00, 2'b10, 8'h00, 8'h00);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
